data_sram_like_slave: RTL and testbench

- Responder end of the CPU data-side sram-like interface: it accepts req/addr_ok address phases and returns in-order data_ok/rdata responses.
- Wraps a word-addressed memory array, supports byte-strobed writes, and keeps up to DEPTH outstanding transactions.
- Each transaction has a fixed minimum latency; an external stall input lets the bench throttle both handshake phases.
- Sits between the MEM-side master (data_sram_* signals) and memory; used as the data RAM model in simulation and as a latency-tolerant local RAM.

---
 rtl/data_sram_like_slave_pkg.sv | 38 +++
 rtl/data_sram_like_slave_resp_fifo.sv | 91 +++++++++
 rtl/data_sram_like_slave.sv | 108 ++++++++++
 tb/tb_data_sram_like_slave.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_sram_like_slave_pkg.sv
// Shared types for the data-side sram-like responder: size encodings,
// response-queue entry layout and the byte-strobe merge helper.
package data_sram_like_slave_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned STRB_W  = DATA_W / 8;
    localparam int unsigned AGE_W   = 4;
    localparam int unsigned ENTRY_W = 1 + DATA_W + AGE_W;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2
    } size_e;

    typedef struct packed {
        logic              wr;
        logic [DATA_W-1:0] data;
        logic [AGE_W-1:0]  age;
    } resp_entry_t;

    // Replace only the byte lanes whose strobe bit is set.
    function automatic logic [DATA_W-1:0] strobe_merge(
        input logic [DATA_W-1:0] old_word,
        input logic [DATA_W-1:0] new_word,
        input logic [STRB_W-1:0] strb
    );
        logic [DATA_W-1:0] res;
        res = old_word;
        for (int i = 0; i < int'(STRB_W); i++) begin
            if (strb[i]) begin
                res[i*8 +: 8] = new_word[i*8 +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/data_sram_like_slave_resp_fifo.sv
// In-order response queue: DEPTH-entry circular buffer whose entries age
// every cycle, so the head can be released once it is old enough.
module sram_like_resp_fifo
    import data_sram_like_slave_pkg::*;
#(
    parameter int unsigned DEPTH   = 2,
    parameter int unsigned LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              push_wr,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic              full_c,
    output logic              empty_c,
    output logic              head_ready_c,
    output logic [DATA_W-1:0] head_data_c
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    resp_entry_t            ent_q [DEPTH];
    resp_entry_t            ent_d [DEPTH];
    logic [DEPTH-1:0]       vld_q, vld_d;
    logic [PTR_W-1:0]       head_q, head_d;
    logic [PTR_W-1:0]       tail_q, tail_d;
    logic [CNT_W-1:0]       count_q, count_d;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full_c       = (count_q == CNT_W'(DEPTH));
    assign empty_c      = (count_q == '0);
    assign head_ready_c = vld_q[head_q] && (ent_q[head_q].age >= AGE_W'(LATENCY - 1));
    assign head_data_c  = ent_q[head_q].data;

    // Age all live entries, then retire the head and/or append at the tail.
    // Push is applied after pop so a full queue can refill the freed slot.
    always_comb begin
        ent_d   = ent_q;
        vld_d   = vld_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;

        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (vld_q[i] && (ent_q[i].age < AGE_W'(LATENCY))) begin
                ent_d[i].age = ent_q[i].age + AGE_W'(1);
            end
        end

        if (pop) begin
            vld_d[head_q] = 1'b0;
            head_d        = ptr_inc(head_q);
        end

        if (push) begin
            ent_d[tail_q].wr   = push_wr;
            ent_d[tail_q].data = push_data;
            ent_d[tail_q].age  = '0;
            vld_d[tail_q]      = 1'b1;
            tail_d             = ptr_inc(tail_q);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ent_q   <= '{default: '0};
            vld_q   <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            ent_q   <= ent_d;
            vld_q   <= vld_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/data_sram_like_slave.sv
// Data-side sram-like responder: word memory with byte-strobed writes,
// up to DEPTH outstanding transactions answered in order after LATENCY cycles.
module data_sram_like_slave
    import data_sram_like_slave_pkg::*;
#(
    parameter int unsigned AW      = 12,
    parameter int unsigned DEPTH   = 2,
    parameter int unsigned LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              data_sram_req,
    input  logic              data_sram_wr,
    input  logic [1:0]        data_sram_size,
    input  logic [STRB_W-1:0] data_sram_wstrb,
    input  logic [31:0]       data_sram_addr,
    input  logic [DATA_W-1:0] data_sram_wdata,
    output logic              data_sram_addr_ok,
    output logic              data_sram_data_ok,
    output logic [DATA_W-1:0] data_sram_rdata,
    input  logic              stall
);

    localparam int unsigned WORDS = 1 << AW;

    logic [DATA_W-1:0] mem_q [WORDS];
    logic              mem_we_d;
    logic [DATA_W-1:0] mem_wdata_d;

    logic [AW-1:0]     idx_c;
    logic              push_c;
    logic              pop_c;
    logic [DATA_W-1:0] push_data_c;
    logic              fifo_full_c;
    logic              fifo_empty_c;
    logic              head_ready_c;
    logic [DATA_W-1:0] head_data_c;

    logic              data_ok_q, data_ok_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    // Size is informational and high address bits alias; neither affects behaviour.
    logic              unused_bits_c;
    assign unused_bits_c = ^{data_sram_size, data_sram_addr[31:AW+2], data_sram_addr[1:0]};

    assign idx_c  = data_sram_addr[AW+1:2];
    assign pop_c  = !fifo_empty_c && head_ready_c && !stall;
    assign data_sram_addr_ok = !reset && !stall && (!fifo_full_c || pop_c);
    assign push_c = data_sram_req && data_sram_addr_ok;

    // Reads sample the array in the acceptance cycle; writes land at its end,
    // so a later read always observes an earlier write.
    assign push_data_c = data_sram_wr ? '0 : mem_q[idx_c];

    sram_like_resp_fifo #(
        .DEPTH   (DEPTH),
        .LATENCY (LATENCY)
    ) u_resp_fifo (
        .clk          (clk),
        .reset        (reset),
        .push         (push_c),
        .push_wr      (data_sram_wr),
        .push_data    (push_data_c),
        .pop          (pop_c),
        .full_c       (fifo_full_c),
        .empty_c      (fifo_empty_c),
        .head_ready_c (head_ready_c),
        .head_data_c  (head_data_c)
    );

    always_comb begin
        mem_we_d    = 1'b0;
        mem_wdata_d = strobe_merge(mem_q[idx_c], data_sram_wdata, data_sram_wstrb);
        if (push_c && data_sram_wr) begin
            mem_we_d = 1'b1;
        end
    end

    // Memory contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we_d) begin
            mem_q[idx_c] <= mem_wdata_d;
        end
    end

    always_comb begin
        data_ok_d = 1'b0;
        rdata_d   = rdata_q;
        if (pop_c) begin
            data_ok_d = 1'b1;
            rdata_d   = head_data_c;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_ok_q <= 1'b0;
            rdata_q   <= '0;
        end else begin
            data_ok_q <= data_ok_d;
            rdata_q   <= rdata_d;
        end
    end

    assign data_sram_data_ok = data_ok_q;
    assign data_sram_rdata   = rdata_q;

endmodule

// File: tb/tb_data_sram_like_slave.sv
// Directed bench: three responder configurations share one master stimulus;
// each scenario watches the configuration it targets.
module tb_data_sram_like_slave;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req = 1'b0;
    logic        wr = 1'b0;
    logic [1:0]  size = 2'd2;
    logic [3:0]  wstrb = 4'h0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic        stall = 1'b0;

    logic        aok_a, dok_a, aok_b, dok_b, aok_c, dok_c;
    logic [31:0] rd_a, rd_b, rd_c;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    int          qa_cyc[$], qb_cyc[$], qc_cyc[$];
    logic [31:0] qa_dat[$], qb_dat[$], qc_dat[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    data_sram_like_slave #(.AW(12), .DEPTH(2), .LATENCY(2)) u_a (
        .clk(clk), .reset(reset), .data_sram_req(req), .data_sram_wr(wr),
        .data_sram_size(size), .data_sram_wstrb(wstrb), .data_sram_addr(addr),
        .data_sram_wdata(wdata), .data_sram_addr_ok(aok_a), .data_sram_data_ok(dok_a),
        .data_sram_rdata(rd_a), .stall(stall));

    data_sram_like_slave #(.AW(12), .DEPTH(2), .LATENCY(3)) u_b (
        .clk(clk), .reset(reset), .data_sram_req(req), .data_sram_wr(wr),
        .data_sram_size(size), .data_sram_wstrb(wstrb), .data_sram_addr(addr),
        .data_sram_wdata(wdata), .data_sram_addr_ok(aok_b), .data_sram_data_ok(dok_b),
        .data_sram_rdata(rd_b), .stall(stall));

    data_sram_like_slave #(.AW(12), .DEPTH(1), .LATENCY(1)) u_c (
        .clk(clk), .reset(reset), .data_sram_req(req), .data_sram_wr(wr),
        .data_sram_size(size), .data_sram_wstrb(wstrb), .data_sram_addr(addr),
        .data_sram_wdata(wdata), .data_sram_addr_ok(aok_c), .data_sram_data_ok(dok_c),
        .data_sram_rdata(rd_c), .stall(stall));

    // Record every response with the cycle it was visible in.
    always @(negedge clk) begin
        if (dok_a) begin qa_cyc.push_back(cyc); qa_dat.push_back(rd_a); end
        if (dok_b) begin qb_cyc.push_back(cyc); qb_dat.push_back(rd_b); end
        if (dok_c) begin qc_cyc.push_back(cyc); qc_dat.push_back(rd_c); end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic logic aok(input int sel);
        return (sel == 0) ? aok_a : (sel == 1) ? aok_b : aok_c;
    endfunction

    task automatic clear_q();
        qa_cyc.delete(); qa_dat.delete();
        qb_cyc.delete(); qb_dat.delete();
        qc_cyc.delete(); qc_dat.delete();
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; req = 1'b0; stall = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        clear_q();
    endtask

    // Present one request and hold it until the selected responder accepts it.
    task automatic do_req(input int sel, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] s,
                          output int acc, output int waits);
        req = 1'b1; wr = w; addr = a; wdata = d; wstrb = s;
        size = ($countones(s) == 4) ? 2'd2 : ($countones(s) == 2) ? 2'd1 : 2'd0;
        waits = 0;
        acc = -1;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (aok(sel)) begin
                acc = cyc + 1;
                break;
            end
            waits++;
            @(posedge clk); #1;
        end
        if (acc < 0) begin
            total++; bad++;
            $display("FAIL req_timeout sel=%0d addr=%h: never accepted", sel, a);
        end
        @(posedge clk); #1;
        req = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++; if (aok_a !== 1'b0) begin bad++; $display("FAIL rst_aok_a got=%b want=0", aok_a); end
        total++; if (aok_c !== 1'b0) begin bad++; $display("FAIL rst_aok_c got=%b want=0", aok_c); end
        total++; if (dok_a !== 1'b0) begin bad++; $display("FAIL rst_dok_a got=%b want=0", dok_a); end
        total++; if (rd_a !== 32'h0) begin bad++; $display("FAIL rst_rdata_a got=%h want=0", rd_a); end
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        total++; if (aok_a !== 1'b1) begin bad++; $display("FAIL post_rst_aok got=%b want=1", aok_a); end
        @(posedge clk); #1;
        clear_q();
    endtask

    task automatic test_write_read();
        int acc0, acc1, w0, w1;
        do_reset();
        do_req(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, acc0, w0);
        do_req(0, 1'b0, 32'h10, 32'h0, 4'h0, acc1, w1);
        wait_cycles(6);
        total++; if (acc1 !== acc0 + 1) begin bad++; $display("FAIL wr_rd_accept got=%0d want=%0d", acc1, acc0 + 1); end
        total++;
        if (qa_cyc.size() != 2) begin
            bad++; $display("FAIL wr_rd_count got=%0d want=2", qa_cyc.size());
        end else begin
            total++; if (qa_cyc[0] !== acc0 + 2) begin bad++; $display("FAIL wr_lat got=%0d want=%0d", qa_cyc[0], acc0 + 2); end
            total++; if (qa_dat[0] !== 32'h0) begin bad++; $display("FAIL wr_rdata got=%h want=0", qa_dat[0]); end
            total++; if (qa_cyc[1] !== acc1 + 2) begin bad++; $display("FAIL rd_lat got=%0d want=%0d", qa_cyc[1], acc1 + 2); end
            total++; if (qa_dat[1] !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_data got=%h want=deadbeef", qa_dat[1]); end
        end
    endtask

    task automatic test_byte_strobe();
        logic [31:0] a_v [6] = '{32'h20, 32'h20, 32'h20, 32'hF0000030, 32'h30, 32'h30};
        logic [31:0] d_v [6] = '{32'h11223344, 32'h0000AA00, 32'h0, 32'hCAFEF00D, 32'hBEEF0000, 32'h0};
        logic [3:0]  s_v [6] = '{4'hF, 4'b0010, 4'h0, 4'hF, 4'b1100, 4'h0};
        logic        w_v [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [31:0] exp_v [6] = '{32'h0, 32'h0, 32'h1122AA44, 32'h0, 32'h0, 32'hBEEFF00D};
        int acc [6];
        int w;
        do_reset();
        for (int i = 0; i < 6; i++) do_req(0, w_v[i], a_v[i], d_v[i], s_v[i], acc[i], w);
        wait_cycles(6);
        total++;
        if (qa_cyc.size() != 6) begin
            bad++; $display("FAIL strb_count got=%0d want=6", qa_cyc.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                total++; if (qa_dat[i] !== exp_v[i]) begin bad++; $display("FAIL strb_data[%0d] got=%h want=%h", i, qa_dat[i], exp_v[i]); end
                total++; if (qa_cyc[i] !== acc[i] + 2) begin bad++; $display("FAIL strb_lat[%0d] got=%0d want=%0d", i, qa_cyc[i], acc[i] + 2); end
            end
        end
    endtask

    task automatic test_stall();
        int acc0, acc1, w, rel;
        do_reset();
        do_req(0, 1'b0, 32'h10, 32'h0, 4'h0, acc0, w);
        do_req(0, 1'b0, 32'h20, 32'h0, 4'h0, acc1, w);
        stall = 1'b1; req = 1'b1; wr = 1'b0; addr = 32'h30;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++; if (aok_a !== 1'b0) begin bad++; $display("FAIL stall_aok[%0d] got=%b want=0", i, aok_a); end
            total++; if (dok_a !== 1'b0) begin bad++; $display("FAIL stall_dok[%0d] got=%b want=0", i, dok_a); end
            @(posedge clk); #1;
        end
        stall = 1'b0; req = 1'b0;
        rel = cyc;
        wait_cycles(6);
        total++;
        if (qa_cyc.size() != 2) begin
            bad++; $display("FAIL stall_count got=%0d want=2", qa_cyc.size());
        end else begin
            total++; if (qa_cyc[0] !== rel + 1) begin bad++; $display("FAIL stall_first got=%0d want=%0d", qa_cyc[0], rel + 1); end
            total++; if (qa_cyc[1] !== rel + 2) begin bad++; $display("FAIL stall_second got=%0d want=%0d", qa_cyc[1], rel + 2); end
            total++; if (qa_dat[0] !== 32'hDEADBEEF) begin bad++; $display("FAIL stall_d0 got=%h want=deadbeef", qa_dat[0]); end
            total++; if (qa_dat[1] !== 32'h1122AA44) begin bad++; $display("FAIL stall_d1 got=%h want=1122aa44", qa_dat[1]); end
        end
    endtask

    task automatic test_reset_midflight();
        int acc0, acc1, w, stray;
        do_reset();
        do_req(0, 1'b0, 32'h10, 32'h0, 4'h0, acc0, w);
        do_req(0, 1'b0, 32'h20, 32'h0, 4'h0, acc1, w);
        reset = 1'b1;
        #1;
        total++; if (aok_a !== 1'b0) begin bad++; $display("FAIL midrst_aok got=%b want=0", aok_a); end
        total++; if (dok_a !== 1'b0) begin bad++; $display("FAIL midrst_dok got=%b want=0", dok_a); end
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        clear_q();
        stray = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (dok_a !== 1'b0) stray++;
            total++; if (aok_a !== 1'b1) begin bad++; $display("FAIL midrst_aok_after[%0d] got=%b want=1", i, aok_a); end
        end
        total++; if (stray !== 0) begin bad++; $display("FAIL midrst_stray got=%0d want=0", stray); end
        total++; if (rd_a !== 32'h0) begin bad++; $display("FAIL midrst_rdata got=%h want=0", rd_a); end
    endtask

    task automatic test_full_queue();
        int acc [4];
        int w, waits;
        for (int i = 0; i < 4; i++) do_req(1, 1'b1, 32'h40 + 32'(4 * i), 32'hA0 + 32'(i), 4'hF, acc[i], w);
        wait_cycles(8);
        do_reset();
        waits = 0;
        for (int i = 0; i < 4; i++) begin
            do_req(1, 1'b0, 32'h40 + 32'(4 * i), 32'h0, 4'h0, acc[i], w);
            waits += w;
        end
        wait_cycles(10);
        total++; if (waits !== 1) begin bad++; $display("FAIL full_waits got=%0d want=1", waits); end
        total++;
        if (qb_cyc.size() != 4) begin
            bad++; $display("FAIL full_count got=%0d want=4", qb_cyc.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                total++; if (qb_cyc[i] !== acc[i] + 3) begin bad++; $display("FAIL full_lat[%0d] got=%0d want=%0d", i, qb_cyc[i], acc[i] + 3); end
                total++; if (qb_dat[i] !== 32'hA0 + 32'(i)) begin bad++; $display("FAIL full_data[%0d] got=%h want=%h", i, qb_dat[i], 32'hA0 + 32'(i)); end
            end
            total++; if (acc[2] !== qb_cyc[0]) begin bad++; $display("FAIL full_refill2 got=%0d want=%0d", acc[2], qb_cyc[0]); end
            total++; if (acc[3] !== qb_cyc[1]) begin bad++; $display("FAIL full_refill3 got=%0d want=%0d", acc[3], qb_cyc[1]); end
        end
    endtask

    task automatic test_back_to_back();
        int acc [3];
        int w, waits;
        for (int i = 0; i < 3; i++) do_req(2, 1'b1, 32'(4 * i), 32'h1000 + 32'(4 * i), 4'hF, acc[i], w);
        wait_cycles(4);
        do_reset();
        waits = 0;
        for (int i = 0; i < 3; i++) begin
            do_req(2, 1'b0, 32'(4 * i), 32'h0, 4'h0, acc[i], w);
            waits += w;
        end
        wait_cycles(4);
        total++; if (waits !== 0) begin bad++; $display("FAIL b2b_waits got=%0d want=0", waits); end
        total++; if (acc[2] !== acc[0] + 2) begin bad++; $display("FAIL b2b_accept got=%0d want=%0d", acc[2], acc[0] + 2); end
        total++;
        if (qc_cyc.size() != 3) begin
            bad++; $display("FAIL b2b_count got=%0d want=3", qc_cyc.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                total++; if (qc_cyc[i] !== acc[i] + 1) begin bad++; $display("FAIL b2b_lat[%0d] got=%0d want=%0d", i, qc_cyc[i], acc[i] + 1); end
                total++; if (qc_dat[i] !== 32'h1000 + 32'(4 * i)) begin bad++; $display("FAIL b2b_data[%0d] got=%h want=%h", i, qc_dat[i], 32'h1000 + 32'(4 * i)); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_byte_strobe();
        test_stall();
        test_reset_midflight();
        test_full_queue();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
